// File: rtl/relm_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : relm_div_seq
// Brief    : Iterative radix-4 restoring integer divider with quotient and
//            remainder, signed/unsigned modes, divide-by-zero flag and an
//            early-exit path when the dividend magnitude is below the divisor.
// Revision : 1.0 - initial release
// ============================================================================
module relm_div_seq #(
    parameter int WD    = 32,
    parameter int EARLY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_in,
    input  logic          signed_in,
    input  logic [WD-1:0] n_in,
    input  logic [WD-1:0] d_in,
    output logic          busy_out,
    output logic          valid_out,
    output logic [WD-1:0] q_out,
    output logic [WD-1:0] r_out,
    output logic          dz_out
);

    localparam int CW = (WD / 2 > 1) ? $clog2(WD / 2) : 1;
    localparam logic [CW-1:0] COUNT_INIT = CW'(WD / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t        state;
    logic          sign_n;
    logic          sign_d;
    logic          sgn_mode;
    logic          dz_flag;
    logic          early_flag;
    logic [CW-1:0] count;
    logic [WD-1:0] num;
    logic [WD+1:0] rem;
    logic [WD-1:0] quo;
    logic [WD-1:0] dabs;
    logic [WD+1:0] d3;
    logic [WD-1:0] n_orig;

    logic [WD-1:0] n_abs;
    logic [WD-1:0] d_abs;
    logic          early_hit;
    logic [WD+1:0] rs;
    logic [WD+1:0] d1;
    logic [WD+1:0] d2;
    logic [WD+1:0] rem_next;
    logic [1:0]    digit;
    logic [WD-1:0] q_fix;
    logic [WD-1:0] r_fix;

    // Operand magnitudes; the most negative value negates to itself, which is
    // exactly 2^(WD-1) when read as unsigned.
    assign n_abs = (signed_in && n_in[WD-1]) ? -n_in : n_in;
    assign d_abs = (signed_in && d_in[WD-1]) ? -d_in : d_in;

    generate
        if (EARLY != 0) begin : g_early
            assign early_hit = (n_abs < d_abs);
        end else begin : g_no_early
            assign early_hit = 1'b0;
        end
    endgenerate

    // Partial remainder shifted by one radix-4 digit; rem stays below |d|, so
    // its top bits are always zero and the shift cannot overflow.
    assign rs = (rem << 2) | {{WD{1'b0}}, num[WD-1:WD-2]};
    assign d1 = {2'b00, dabs};
    assign d2 = {1'b0, dabs, 1'b0};

    // Pick the largest multiple of |d| that fits and form the quotient digit.
    always_comb begin
        digit    = 2'd0;
        rem_next = rs;
        if (rs >= d3) begin
            digit    = 2'd3;
            rem_next = rs - d3;
        end else if (rs >= d2) begin
            digit    = 2'd2;
            rem_next = rs - d2;
        end else if (rs >= d1) begin
            digit    = 2'd1;
            rem_next = rs - d1;
        end
    end

    // Sign fix-up: quotient truncates toward zero, remainder follows dividend.
    assign q_fix = (sgn_mode && (sign_n ^ sign_d)) ? -quo : quo;
    assign r_fix = (sgn_mode && sign_n) ? -rem[WD-1:0] : rem[WD-1:0];

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            sign_n     <= 1'b0;
            sign_d     <= 1'b0;
            sgn_mode   <= 1'b0;
            dz_flag    <= 1'b0;
            early_flag <= 1'b0;
            count      <= '0;
            num        <= '0;
            rem        <= '0;
            quo        <= '0;
            dabs       <= '0;
            d3         <= '0;
            n_orig     <= '0;
            busy_out   <= 1'b0;
            valid_out  <= 1'b0;
            q_out      <= '0;
            r_out      <= '0;
            dz_out     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    valid_out <= 1'b0;
                    if (start_in) begin
                        sign_n     <= signed_in & n_in[WD-1];
                        sign_d     <= signed_in & d_in[WD-1];
                        sgn_mode   <= signed_in;
                        dz_flag    <= (d_in == '0);
                        early_flag <= early_hit;
                        count      <= COUNT_INIT;
                        num        <= n_abs;
                        rem        <= '0;
                        quo        <= '0;
                        dabs       <= d_abs;
                        d3         <= {2'b00, d_abs} + {1'b0, d_abs, 1'b0};
                        n_orig     <= n_in;
                        dz_out     <= 1'b0;
                        busy_out   <= 1'b1;
                        state      <= ((d_in == '0) || early_hit) ? S_FIX : S_RUN;
                    end
                end
                S_RUN: begin
                    rem   <= rem_next;
                    num   <= num << 2;
                    quo   <= {quo[WD-3:0], digit};
                    count <= count - CW'(1);
                    if (count == '0) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (dz_flag) begin
                        q_out  <= '1;
                        r_out  <= n_orig;
                        dz_out <= 1'b1;
                    end else if (early_flag) begin
                        q_out  <= '0;
                        r_out  <= n_orig;
                        dz_out <= 1'b0;
                    end else begin
                        q_out  <= q_fix;
                        r_out  <= r_fix;
                        dz_out <= 1'b0;
                    end
                    valid_out <= 1'b1;
                    busy_out  <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    busy_out  <= 1'b0;
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_relm_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_relm_div_seq
// Brief    : Self-checking bench for relm_div_seq: one instance without and one
//            with early exit, scoreboard queues of expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_relm_div_seq;

    localparam int WD = 32;

    typedef struct {
        logic [WD-1:0] q;
        logic [WD-1:0] r;
        logic          dz;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start0;
    logic          start1;
    logic          signed_in;
    logic [WD-1:0] n_in;
    logic [WD-1:0] d_in;
    logic          busy0, valid0, dz0;
    logic          busy1, valid1, dz1;
    logic [WD-1:0] q0, r0, q1, r1;

    exp_t sb0[$];
    exp_t sb1[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    relm_div_seq #(.WD(WD), .EARLY(0)) dut0 (
        .clk(clk), .rst(rst), .start_in(start0), .signed_in(signed_in),
        .n_in(n_in), .d_in(d_in), .busy_out(busy0), .valid_out(valid0),
        .q_out(q0), .r_out(r0), .dz_out(dz0)
    );

    relm_div_seq #(.WD(WD), .EARLY(1)) dut1 (
        .clk(clk), .rst(rst), .start_in(start1), .signed_in(signed_in),
        .n_in(n_in), .d_in(d_in), .busy_out(busy1), .valid_out(valid1),
        .q_out(q1), .r_out(r1), .dz_out(dz1)
    );

    task automatic chk(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: 64-bit native division, which cannot overflow for WD=32.
    task automatic model(input logic [WD-1:0] n, input logic [WD-1:0] d, input bit sg,
                         input bit early_en, output logic [WD-1:0] q, output logic [WD-1:0] r,
                         output bit dz, output int lat);
        longint a, b, qq, rr;
        logic [WD-1:0] an, ad;
        if (d == '0) begin
            q = '1; r = n; dz = 1'b1; lat = 1;
        end else begin
            a  = sg ? longint'($signed(n)) : longint'({32'b0, n});
            b  = sg ? longint'($signed(d)) : longint'({32'b0, d});
            qq = a / b;
            rr = a % b;
            q  = qq[WD-1:0];
            r  = rr[WD-1:0];
            dz = 1'b0;
            an = (sg && n[WD-1]) ? -n : n;
            ad = (sg && d[WD-1]) ? -d : d;
            lat = (early_en && (an < ad)) ? 1 : 17;
        end
    endtask

    // Issue one operation, wait (bounded) for valid, then score the result.
    task automatic run(input bit which, input logic [WD-1:0] n, input logic [WD-1:0] d,
                       input bit sg, input logic [WD-1:0] eq, input logic [WD-1:0] er,
                       input bit edz, input int elat, input bit spam);
        exp_t e, got;
        int   lat;
        bit   seen;
        e.q = eq; e.r = er; e.dz = edz;
        if (which) sb1.push_back(e); else sb0.push_back(e);
        n_in = n; d_in = d; signed_in = sg;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0; start1 = 1'b0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            if (spam) begin
                if (which) start1 = 1'b1; else start0 = 1'b1;
                n_in = $urandom; d_in = $urandom; signed_in = $urandom_range(0, 1);
            end
            @(posedge clk);
            lat++;
            #1;
            seen = which ? valid1 : valid0;
        end
        start0 = 1'b0; start1 = 1'b0;
        chk("latency", WD'(lat), WD'(elat));
        if ((which ? sb1.size() : sb0.size()) == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            got = which ? sb1.pop_front() : sb0.pop_front();
            chk("q", which ? q1 : q0, got.q);
            chk("r", which ? r1 : r0, got.r);
            chk("dz", WD'(which ? dz1 : dz0), WD'(got.dz));
            chk("busy_after", WD'(which ? busy1 : busy0), 32'd0);
        end
    endtask

    initial begin
        logic [WD-1:0] rn, rd, rq, rr;
        bit            rsg, rdz, which;
        int            rlat, vcount;

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; signed_in = 1'b0;
        n_in = '0; d_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", WD'(busy0), 32'd0);
        chk("rst_valid", WD'(valid0), 32'd0);
        chk("rst_q", q0, 32'd0);
        chk("rst_r", r0, 32'd0);
        chk("rst_dz", WD'(dz0), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases, full-iteration instance.
        run(0, 32'd100, 32'd7, 0, 32'd14, 32'd2, 0, 17, 0);
        run(0, -32'sd7, 32'd2, 1, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 17, 0);
        run(0, 32'd7, -32'sd2, 1, 32'hFFFFFFFD, 32'd1, 0, 17, 0);
        run(0, 32'h1234, 32'd0, 0, 32'hFFFFFFFF, 32'h1234, 1, 1, 0);
        @(posedge clk);
        #1;
        chk("valid_one_cycle", WD'(valid0), 32'd0);
        chk("dz_held", WD'(dz0), 32'd1);
        run(0, 32'd100, 32'd7, 0, 32'd14, 32'd2, 0, 17, 0);
        run(0, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 32'd0, 0, 17, 0);
        run(0, 32'hFFFFFFFF, 32'd1, 0, 32'hFFFFFFFF, 32'd0, 0, 17, 0);
        run(0, 32'd1000, 32'd10, 0, 32'd100, 32'd0, 0, 17, 1);
        @(posedge clk);
        #1;
        chk("spam_no_restart", WD'(busy0), 32'd0);

        // Early-exit instance, including back-to-back issue.
        run(1, 32'd5, 32'd9, 0, 32'd0, 32'd5, 0, 1, 0);
        run(1, 32'd100, 32'd7, 0, 32'd14, 32'd2, 0, 17, 0);
        run(1, -32'sd5, 32'd9, 1, 32'd0, 32'hFFFFFFFB, 0, 1, 0);
        run(1, 32'd0, 32'd0, 1, 32'hFFFFFFFF, 32'd0, 1, 1, 0);

        // Reset in the middle of an operation.
        n_in = 32'd100; d_in = 32'd7; signed_in = 1'b0; start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_busy_before", WD'(busy0), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", WD'(busy0), 32'd0);
        chk("abort_q", q0, 32'd0);
        chk("abort_r", r0, 32'd0);
        chk("abort_dz", WD'(dz1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (valid0) vcount++;
        end
        chk("abort_no_valid", WD'(vcount), 32'd0);

        // Random operations against the reference model, both instances.
        for (int i = 0; i < 2000; i++) begin
            which = i[0];
            rn  = $urandom;
            rd  = $urandom;
            rsg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rd = rd >> $urandom_range(0, 31);
                1: rd = rd & 32'h000000FF;
                2: rd = '0;
                3: begin rn = 32'h80000000; rd = 32'hFFFFFFFF; end
                4: rn = rn >> $urandom_range(0, 31);
                default: ;
            endcase
            model(rn, rd, rsg, which, rq, rr, rdz, rlat);
            run(which, rn, rd, rsg, rq, rr, rdz, rlat, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
